// File: rtl/mem_bus_pkg.sv
// mem_bus_pkg: shared FSM states, access-size codes and default bank map for the memory bus controller
package mem_bus_pkg;
  typedef enum logic [1:0] {IDLE, ACCESS, DONE, ERROR} state_t;
  localparam logic [1:0] SZ_WORD = 2'd0;
  localparam logic [1:0] SZ_HALF = 2'd1;
  localparam logic [1:0] SZ_BYTE = 2'd2;
  localparam logic [1:0] SZ_ILL = 2'd3;
  localparam int DEF_NBANKS = 3;
  localparam int DEF_PHYS_W = 13;
  localparam logic [DEF_NBANKS*32-1:0] DEF_BANK_BASE = {32'h7FFF0000, 32'h7FFE0000, 32'h10010000};
  localparam logic [DEF_NBANKS*4-1:0] DEF_BANK_WAIT = {4'd0, 4'd2, 4'd0};
endpackage

// File: rtl/mem_lane_codec.sv
// mem_lane_codec: little-endian byte-lane encode for stores, lane extract and extend for loads
module mem_lane_codec
  import mem_bus_pkg::*;
(
  input  logic [1:0]  size,
  input  logic [1:0]  offset,
  input  logic        zext,
  input  logic [31:0] storeData,
  input  logic [31:0] loadWord,
  output logic [3:0]  laneMask,
  output logic [31:0] storeRep,
  output logic [31:0] loadVal
);
  logic [15:0] halfSel;
  logic [7:0]  byteSel;
  always_comb begin
    halfSel = offset[1] ? loadWord[31:16] : loadWord[15:0];
    byteSel = loadWord[{offset, 3'b000} +: 8];
    laneMask = size == SZ_WORD ? 4'b1111 : size == SZ_HALF ? (offset[1] ? 4'b1100 : 4'b0011) : 4'b0001 << offset;
    storeRep = size == SZ_WORD ? storeData : size == SZ_HALF ? {2{storeData[15:0]}} : {4{storeData[7:0]}};
    loadVal = size == SZ_WORD ? loadWord :
              size == SZ_HALF ? {{16{~zext & halfSel[15]}}, halfSel} : {{24{~zext & byteSel[7]}}, byteSel};
  end
endmodule

// File: rtl/mem_bus_ctrl.sv
// mem_bus_ctrl: maps CPU loads/stores onto memory-mapped banks with per-bank wait states
// and a sticky fault state for unmapped or misaligned accesses.
module mem_bus_ctrl
  import mem_bus_pkg::*;
#(
  parameter int NBANKS = DEF_NBANKS,
  parameter int PHYS_W = DEF_PHYS_W,
  parameter logic [NBANKS*32-1:0] BANK_BASE = DEF_BANK_BASE,
  parameter logic [NBANKS*4-1:0]  BANK_WAIT = DEF_BANK_WAIT
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 cpu_req,
  input  logic                 cpu_we,
  input  logic [31:0]          cpu_addr,
  input  logic [31:0]          cpu_wdata,
  input  logic [1:0]           cpu_size,
  input  logic                 cpu_zext,
  output logic [31:0]          cpu_rdata,
  output logic                 cpu_ready,
  output logic                 cpu_stall,
  output logic                 cpu_err,
  output logic [31:0]          err_addr,
  input  logic                 err_clr,
  output logic [NBANKS-1:0]    bank_en,
  output logic [3:0]           bank_we,
  output logic [PHYS_W-3:0]    bank_addr,
  output logic [31:0]          bank_wdata,
  input  logic [NBANKS*32-1:0] bank_rdata
);
  localparam int BW = NBANKS > 1 ? $clog2(NBANKS) : 1;
  state_t state, nextState;
  logic [PHYS_W-1:0] addrQ;
  logic [31:0] wdataQ, loadVal;
  logic [1:0] sizeQ;
  logic weQ, zextQ, hit, legal, lastAccess;
  logic [BW-1:0] bankQ, hitBank;
  logic [3:0] waitCnt, laneMask;
  // Descending scan so the lowest-numbered bank wins when windows overlap
  always_comb begin
    hit = 1'b0;
    hitBank = '0;
    for (int b = NBANKS - 1; b >= 0; b--)
      if (cpu_addr[31:PHYS_W] == BANK_BASE[b*32+PHYS_W +: 32-PHYS_W]) begin
        hit = 1'b1;
        hitBank = BW'(b);
      end
    legal = hit && cpu_size != SZ_ILL && !(cpu_size == SZ_WORD && cpu_addr[1:0] != 2'b00)
            && !(cpu_size == SZ_HALF && cpu_addr[0]);
  end
  assign lastAccess = state == ACCESS && waitCnt == 4'd0;
  assign bank_addr = addrQ[PHYS_W-1:2];
  always_ff @(posedge clk or negedge rst)
    if (!rst) state <= IDLE;
    else state <= nextState;
  always_comb begin
    nextState = state;
    cpu_ready = state == DONE;
    cpu_err = state == ERROR;
    cpu_stall = cpu_err | (cpu_req & ~cpu_ready);
    bank_en = state == ACCESS ? NBANKS'(1) << bankQ : '0;
    bank_we = lastAccess && weQ ? laneMask : 4'b0000;
    case (state)
      IDLE:    nextState = cpu_req ? (legal ? ACCESS : ERROR) : IDLE;
      ACCESS:  nextState = waitCnt == 4'd0 ? DONE : ACCESS;
      DONE:    nextState = IDLE;
      ERROR:   nextState = err_clr ? IDLE : ERROR;
      default: nextState = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      addrQ <= '0;
      wdataQ <= '0;
      sizeQ <= SZ_WORD;
      weQ <= 1'b0;
      zextQ <= 1'b0;
      bankQ <= '0;
      waitCnt <= '0;
      err_addr <= '0;
      cpu_rdata <= '0;
    end else begin
      if (state == IDLE && cpu_req && legal) begin
        addrQ <= cpu_addr[PHYS_W-1:0];
        wdataQ <= cpu_wdata;
        sizeQ <= cpu_size;
        weQ <= cpu_we;
        zextQ <= cpu_zext;
        bankQ <= hitBank;
        waitCnt <= BANK_WAIT[hitBank*4 +: 4];
      end else if (state == ACCESS && waitCnt != 4'd0)
        waitCnt <= waitCnt - 4'd1;
      if (state == IDLE && cpu_req && !legal) err_addr <= cpu_addr;
      if (lastAccess) cpu_rdata <= loadVal;
    end
  end
  mem_lane_codec codec (
    .size(sizeQ),
    .offset(addrQ[1:0]),
    .zext(zextQ),
    .storeData(wdataQ),
    .loadWord(bank_rdata[bankQ*32 +: 32]),
    .laneMask(laneMask),
    .storeRep(bank_wdata),
    .loadVal(loadVal)
  );
endmodule

// File: tb/tb_mem_bus_ctrl.sv
// tb_mem_bus_ctrl: directed vectors for mem_bus_ctrl; the driver queues expected responses,
// a negedge monitor pops and compares them whenever the DUT completes or faults.
module tb_mem_bus_ctrl;
  import mem_bus_pkg::*;
  typedef struct {
    bit isErr;
    bit chkRd;
    logic [31:0] rdata;
    logic [31:0] eaddr;
    logic [2:0] en;
    logic [3:0] we;
    logic [10:0] baddr;
    logic [31:0] wdata;
    int lat;
    int stall;
    int writes;
  } exp_t;
  logic clk = 0, rst = 0, cpu_req = 0, cpu_we = 0, cpu_zext = 0, err_clr = 0;
  logic [31:0] cpu_addr = 0, cpu_wdata = 0;
  logic [1:0] cpu_size = 0;
  logic [31:0] cpu_rdata, err_addr, bank_wdata;
  logic cpu_ready, cpu_stall, cpu_err;
  logic [2:0] bank_en;
  logic [3:0] bank_we;
  logic [10:0] bank_addr;
  logic [31:0] bw0 = 0, bw1 = 0, bw2 = 0;
  exp_t q[$];
  int total = 0, bad = 0, cyc = 0, issueCyc = 0, stallCnt = 0, writes = 0;
  bit errSeen = 0;
  mem_bus_ctrl dut (
    .clk(clk), .rst(rst), .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr),
    .cpu_wdata(cpu_wdata), .cpu_size(cpu_size), .cpu_zext(cpu_zext), .cpu_rdata(cpu_rdata),
    .cpu_ready(cpu_ready), .cpu_stall(cpu_stall), .cpu_err(cpu_err), .err_addr(err_addr),
    .err_clr(err_clr), .bank_en(bank_en), .bank_we(bank_we), .bank_addr(bank_addr),
    .bank_wdata(bank_wdata), .bank_rdata({bw2, bw1, bw0})
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s: got %h want %h (t=%0t)", name, act, want, $time);
    end
  endtask
  function automatic exp_t ld(logic [2:0] en, logic [10:0] ba, logic [31:0] rd, int lat);
    exp_t e = '{default: 0};
    e.en = en; e.baddr = ba; e.rdata = rd; e.chkRd = 1; e.lat = lat; e.stall = lat;
    return e;
  endfunction
  function automatic exp_t st(logic [2:0] en, logic [3:0] we, logic [10:0] ba, logic [31:0] wd, int lat);
    exp_t e = '{default: 0};
    e.en = en; e.we = we; e.baddr = ba; e.wdata = wd; e.lat = lat; e.stall = lat; e.writes = 1;
    return e;
  endfunction
  function automatic exp_t er(logic [31:0] a);
    exp_t e = '{default: 0};
    e.isErr = 1; e.eaddr = a;
    return e;
  endfunction
  // Monitor: bank-side activity is checked against the head of the queue, completions pop it
  always @(negedge clk) begin
    exp_t e;
    if (!cpu_err) errSeen = 0;
    if (bank_en != 0) begin
      if (q.size() == 0) chk("stray_bank_en", 32'(bank_en), 0);
      else begin
        chk("bank_en", 32'(bank_en), 32'(q[0].en));
        chk("bank_addr", 32'(bank_addr), 32'(q[0].baddr));
      end
    end
    if (bank_we != 0) begin
      if (q.size() == 0) chk("stray_write", 32'(bank_we), 0);
      else begin
        chk("bank_we", 32'(bank_we), 32'(q[0].we));
        chk("bank_wdata", bank_wdata, q[0].wdata);
        writes++;
      end
    end
    if (cpu_ready) begin
      if (q.size() == 0) chk("spurious_ready", 32'(cpu_ready), 0);
      else begin
        e = q.pop_front();
        chk("ready_kind", 32'(cpu_err), 32'(e.isErr));
        chk("latency", cyc - issueCyc, e.lat);
        if (e.stall >= 0) chk("stall_cycles", stallCnt, e.stall);
        if (e.chkRd) chk("rdata", cpu_rdata, e.rdata);
        chk("write_count", writes, e.writes);
      end
      stallCnt = 0;
      writes = 0;
    end else if (cpu_err && !errSeen) begin
      errSeen = 1;
      if (q.size() == 0) chk("spurious_err", 32'(cpu_err), 0);
      else begin
        e = q.pop_front();
        chk("err_kind", 32'(cpu_err), 32'(e.isErr));
        chk("err_addr", err_addr, e.eaddr);
        chk("err_bank_en", 32'(bank_en), 0);
        chk("err_writes", writes, 0);
      end
      stallCnt = 0;
      writes = 0;
    end else if (q.size() != 0 && cyc >= issueCyc && cpu_stall) stallCnt++;
  end
  // Latency is counted in edges after the sampling edge: BANK_WAIT+1, i.e. the
  // ready cycle is the (BANK_WAIT+2)th cycle counting the one where the request is seen.
  task automatic run(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                     input logic [1:0] size, input logic zext, input exp_t e, input bit dropEarly);
    bit done = 0;
    @(negedge clk);
    if (dropEarly) e.stall = -1;
    q.push_back(e);
    issueCyc = cyc + 1;
    cpu_we = we; cpu_addr = addr; cpu_wdata = wdata; cpu_size = size; cpu_zext = zext;
    cpu_req = 1;
    if (dropEarly) begin
      @(negedge clk);
      cpu_req = 0;
    end
    for (int i = 0; i < 40 && !done; i++) begin
      @(negedge clk);
      done = cpu_ready || cpu_err;
    end
    cpu_req = 0;
    if (!done) begin
      chk("timeout", 32'(done), 1);
      q.delete();
    end else if (cpu_err) begin
      repeat (2) @(negedge clk);
      chk("err_sticky", 32'(cpu_err), 1);
      chk("err_stall", 32'(cpu_stall), 1);
      err_clr = 1;
      @(negedge clk);
      err_clr = 0;
      chk("err_clr_idle", 32'(cpu_err), 0);
      chk("idle_stall", 32'(cpu_stall), 0);
    end
  endtask
  task automatic chkReset(input string tag);
    chk({tag, "_rdata"}, cpu_rdata, 0);
    chk({tag, "_ready"}, 32'(cpu_ready), 0);
    chk({tag, "_err"}, 32'(cpu_err), 0);
    chk({tag, "_err_addr"}, err_addr, 0);
    chk({tag, "_bank_en"}, 32'(bank_en), 0);
    chk({tag, "_bank_we"}, 32'(bank_we), 0);
    chk({tag, "_bank_addr"}, 32'(bank_addr), 0);
    chk({tag, "_bank_wdata"}, bank_wdata, 0);
    chk({tag, "_stall"}, 32'(cpu_stall), 0);
  endtask
  initial begin
    bit ok = 0;
    repeat (2) @(negedge clk);
    chkReset("init");
    rst = 1;
    run(1, 32'h10010008, 32'hDEADBEEF, SZ_WORD, 0, st(3'b001, 4'b1111, 11'd2, 32'hDEADBEEF, 1), 0);
    bw0 = 32'h80FFFFFF;
    run(0, 32'h10010003, 0, SZ_BYTE, 0, ld(3'b001, 11'd0, 32'hFFFFFF80, 1), 0);
    run(0, 32'h10010003, 0, SZ_BYTE, 1, ld(3'b001, 11'd0, 32'h00000080, 1), 0);
    run(1, 32'h7FFE0002, 32'h0000ABCD, SZ_HALF, 0, st(3'b010, 4'b1100, 11'd0, 32'hABCDABCD, 3), 0);
    run(0, 32'h10010001, 0, SZ_WORD, 0, er(32'h10010001), 0);
    run(0, 32'h00000000, 0, SZ_WORD, 0, er(32'h00000000), 0);
    bw2 = 32'h80011234;
    run(0, 32'h7FFF0006, 0, SZ_HALF, 0, ld(3'b100, 11'd1, 32'hFFFF8001, 1), 0);
    bw0 = 32'h1234F00D;
    run(0, 32'h10010000, 0, SZ_HALF, 1, ld(3'b001, 11'd0, 32'h0000F00D, 1), 0);
    run(1, 32'h7FFF0005, 32'h123456A5, SZ_BYTE, 0, st(3'b100, 4'b0010, 11'd1, 32'hA5A5A5A5, 1), 0);
    bw0 = 32'hCAFEF00D;
    run(0, 32'h10011FFC, 0, SZ_WORD, 1, ld(3'b001, 11'h7FF, 32'hCAFEF00D, 1), 0);
    run(0, 32'h10010000, 0, SZ_ILL, 0, er(32'h10010000), 0);
    run(0, 32'h10010001, 0, SZ_HALF, 0, er(32'h10010001), 0);
    run(0, 32'h10012000, 0, SZ_BYTE, 0, er(32'h10012000), 0);
    bw1 = 32'h5A5A0001;
    run(0, 32'h7FFE0010, 0, SZ_WORD, 0, ld(3'b010, 11'd4, 32'h5A5A0001, 3), 1);
    // Reset during the final (writing) ACCESS cycle of a bank-1 store
    @(negedge clk);
    q.push_back(st(3'b010, 4'b0011, 11'd1, 32'h22222222, 3));
    issueCyc = cyc + 1;
    cpu_we = 1; cpu_addr = 32'h7FFE0004; cpu_wdata = 32'h11112222; cpu_size = SZ_HALF; cpu_zext = 0;
    cpu_req = 1;
    for (int i = 0; i < 40 && !ok; i++) begin
      @(negedge clk);
      ok = bank_we != 0;
    end
    chk("reset_setup_write", 32'(ok), 1);
    #1 rst = 0;
    cpu_req = 0;
    #1 chkReset("midreset");
    q.delete();
    writes = 0;
    stallCnt = 0;
    @(negedge clk);
    rst = 1;
    repeat (5) @(negedge clk);
    bw0 = 32'h01020304;
    run(0, 32'h10010004, 0, SZ_WORD, 0, ld(3'b001, 11'd1, 32'h01020304, 1), 0);
    repeat (2) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
